// File: rtl/ias_pkg.sv
// Shared definitions for the IAS controller slice: commit-buffer state
// encodings and the default result width.
package ias_pkg;

    localparam int IAS_DATA_W = 32;

    // Encoding 2'd3 is unused and decodes as idle.
    typedef enum logic [1:0] {
        CB_IDLE = 2'd0,
        CB_ACK  = 2'd1,
        CB_HOLD = 2'd2
    } cb_state_e;

endpackage

// File: rtl/ias_commit_fifo.sv
// Register-based FIFO holding committed results; freeze stalls every update.
module ias_commit_fifo
    import ias_pkg::*;
#(
    parameter int DATA_W = IAS_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     freeze_i,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        data_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o & ~freeze_i;
    assign do_pop  = pop_i & ~empty_o & ~freeze_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ias_commit_buf.sv
// Commit buffer: captures controller results with a one-cycle ack handshake
// and queues them for a valid/ready consumer; scan enable freezes everything.
module ias_commit_buf
    import ias_pkg::*;
#(
    parameter int DATA_W = IAS_DATA_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sen,
    input  logic                     op_commit,
    input  logic [DATA_W-1:0]        res_data,
    output logic                     commit_ack,
    output logic                     out_val,
    input  logic                     out_rdy,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         commit_cnt
);

    cb_state_e         state_q;
    logic [CNT_W-1:0]  commit_cnt_q;
    logic              in_idle;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    assign in_idle    = (state_q != CB_ACK) && (state_q != CB_HOLD);
    // Full is judged before this cycle's pop, so a pop never frees a slot same-cycle.
    assign push       = in_idle & op_commit & ~full & ~sen;
    assign out_val    = ~empty & ~sen;
    assign pop        = out_val & out_rdy;
    assign commit_ack = (state_q == CB_ACK) & ~sen;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= CB_IDLE;
            commit_cnt_q <= '0;
        end else if (!sen) begin
            case (state_q)
                CB_ACK:  state_q <= op_commit ? CB_HOLD : CB_IDLE;
                CB_HOLD: state_q <= op_commit ? CB_HOLD : CB_IDLE;
                default: state_q <= push ? CB_ACK : CB_IDLE;
            endcase
            if (push) begin
                commit_cnt_q <= commit_cnt_q + CNT_W'(1);
            end
        end
    end

    assign commit_cnt = commit_cnt_q;

    ias_commit_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .freeze_i (sen),
        .push_i   (push),
        .data_i   (res_data),
        .pop_i    (pop),
        .data_o   (out_data),
        .count_o  (count),
        .full_o   (full),
        .empty_o  (empty)
    );

endmodule

// File: tb/tb_ias_commit_buf.sv
// Directed self-checking bench for ias_commit_buf (DATA_W 32, DEPTH 4, CNT_W 16).
module tb_ias_commit_buf;

    logic        clk = 1'b0;
    logic        reset;
    logic        sen;
    logic        op_commit;
    logic [31:0] res_data;
    logic        commit_ack;
    logic        out_val;
    logic        out_rdy;
    logic [31:0] out_data;
    logic [2:0]  count;
    logic [15:0] commit_cnt;

    int n_pass  = 0;
    int n_total = 0;

    ias_commit_buf #(.DATA_W(32), .DEPTH(4), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .sen        (sen),
        .op_commit  (op_commit),
        .res_data   (res_data),
        .commit_ack (commit_ack),
        .out_val    (out_val),
        .out_rdy    (out_rdy),
        .out_data   (out_data),
        .count      (count),
        .commit_cnt (commit_cnt)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs set afterwards apply to that cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; sen = 1'b0; op_commit = 1'b0; res_data = '0; out_rdy = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Two-cycle commit: op_commit high in the capture cycle, dropped during the ack.
    task automatic commit(input logic [31:0] v);
        op_commit = 1'b1; res_data = v;
        tick();
        op_commit = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_total++; if (commit_ack !== 1'b0) $display("FAIL rst_ack got %0b exp 0", commit_ack); else n_pass++;
        n_total++; if (out_val !== 1'b0) $display("FAIL rst_val got %0b exp 0", out_val); else n_pass++;
        n_total++; if (out_data !== 32'h0) $display("FAIL rst_data got %h exp 0", out_data); else n_pass++;
        n_total++; if (count !== 3'd0) $display("FAIL rst_count got %0d exp 0", count); else n_pass++;
        n_total++; if (commit_cnt !== 16'd0) $display("FAIL rst_cnt got %0d exp 0", commit_cnt); else n_pass++;
    endtask

    task automatic test_single_commit();
        do_reset();
        op_commit = 1'b1; res_data = 32'h0000_00A5;
        #1;
        n_total++; if (commit_ack !== 1'b0) $display("FAIL single_ack_pre got %0b exp 0", commit_ack); else n_pass++;
        tick();
        n_total++; if (commit_ack !== 1'b1) $display("FAIL single_ack got %0b exp 1", commit_ack); else n_pass++;
        n_total++; if (count !== 3'd1) $display("FAIL single_count got %0d exp 1", count); else n_pass++;
        n_total++; if (out_val !== 1'b1) $display("FAIL single_val got %0b exp 1", out_val); else n_pass++;
        n_total++; if (out_data !== 32'hA5) $display("FAIL single_data got %h exp a5", out_data); else n_pass++;
        n_total++; if (commit_cnt !== 16'd1) $display("FAIL single_cnt got %0d exp 1", commit_cnt); else n_pass++;
        tick();
        op_commit = 1'b0;
        n_total++; if (commit_ack !== 1'b0) $display("FAIL single_ack_post got %0b exp 0", commit_ack); else n_pass++;
        tick();
        n_total++; if (count !== 3'd1) $display("FAIL single_count_post got %0d exp 1", count); else n_pass++;
        n_total++; if (commit_cnt !== 16'd1) $display("FAIL single_cnt_post got %0d exp 1", commit_cnt); else n_pass++;
    endtask

    task automatic test_fill_backpressure();
        do_reset();
        for (int i = 1; i <= 4; i++) commit(32'(i));
        n_total++; if (count !== 3'd4) $display("FAIL fill_count got %0d exp 4", count); else n_pass++;
        op_commit = 1'b1; res_data = 32'd5;
        tick();
        n_total++; if (commit_ack !== 1'b0) $display("FAIL full_ack1 got %0b exp 0", commit_ack); else n_pass++;
        n_total++; if (count !== 3'd4) $display("FAIL full_count got %0d exp 4", count); else n_pass++;
        n_total++; if (commit_cnt !== 16'd4) $display("FAIL full_cnt got %0d exp 4", commit_cnt); else n_pass++;
        tick();
        out_rdy = 1'b1;
        #1;
        n_total++; if (commit_ack !== 1'b0) $display("FAIL full_ack2 got %0b exp 0", commit_ack); else n_pass++;
        n_total++; if (out_data !== 32'd1) $display("FAIL full_head got %0d exp 1", out_data); else n_pass++;
        tick();
        out_rdy = 1'b0;
        n_total++; if (count !== 3'd3) $display("FAIL bp_count got %0d exp 3", count); else n_pass++;
        n_total++; if (commit_ack !== 1'b0) $display("FAIL bp_ack got %0b exp 0", commit_ack); else n_pass++;
        n_total++; if (out_data !== 32'd2) $display("FAIL bp_head got %0d exp 2", out_data); else n_pass++;
        tick();
        op_commit = 1'b0;
        n_total++; if (commit_ack !== 1'b1) $display("FAIL bp_ack5 got %0b exp 1", commit_ack); else n_pass++;
        n_total++; if (count !== 3'd4) $display("FAIL bp_count5 got %0d exp 4", count); else n_pass++;
        n_total++; if (commit_cnt !== 16'd5) $display("FAIL bp_cnt5 got %0d exp 5", commit_cnt); else n_pass++;
        tick();
        n_total++; if (commit_ack !== 1'b0) $display("FAIL bp_ack_end got %0b exp 0", commit_ack); else n_pass++;
    endtask

    task automatic test_push_pop_same_cycle();
        logic [31:0] exp_q [$];
        do_reset();
        commit(32'd1);
        commit(32'd2);
        op_commit = 1'b1; res_data = 32'd3; out_rdy = 1'b1;
        #1;
        n_total++; if (out_data !== 32'd1) $display("FAIL pp_pop_data got %0d exp 1", out_data); else n_pass++;
        tick();
        op_commit = 1'b0; out_rdy = 1'b0;
        n_total++; if (count !== 3'd2) $display("FAIL pp_count got %0d exp 2", count); else n_pass++;
        n_total++; if (commit_ack !== 1'b1) $display("FAIL pp_ack got %0b exp 1", commit_ack); else n_pass++;
        tick();
        commit(32'd4);
        commit(32'd5);
        exp_q = '{32'd2, 32'd3, 32'd4, 32'd5};
        out_rdy = 1'b1;
        foreach (exp_q[i]) begin
            #1;
            n_total++;
            if (out_val !== 1'b1 || out_data !== exp_q[i])
                $display("FAIL drain_%0d got val=%0b data=%0d exp val=1 data=%0d", i, out_val, out_data, exp_q[i]);
            else n_pass++;
            tick();
        end
        out_rdy = 1'b0;
        n_total++; if (out_val !== 1'b0) $display("FAIL drain_empty_val got %0b exp 0", out_val); else n_pass++;
        n_total++; if (count !== 3'd0) $display("FAIL drain_count got %0d exp 0", count); else n_pass++;
    endtask

    task automatic test_slow_producer();
        do_reset();
        op_commit = 1'b1; res_data = 32'h77;
        tick();
        n_total++; if (commit_ack !== 1'b1) $display("FAIL slow_ack got %0b exp 1", commit_ack); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total++;
            if (commit_ack !== 1'b0 || count !== 3'd1 || commit_cnt !== 16'd1)
                $display("FAIL slow_hold_%0d got ack=%0b count=%0d cnt=%0d exp ack=0 count=1 cnt=1",
                         i, commit_ack, count, commit_cnt);
            else n_pass++;
        end
        op_commit = 1'b0;
        tick();
        tick();
        n_total++; if (count !== 3'd1) $display("FAIL slow_count got %0d exp 1", count); else n_pass++;
        n_total++; if (commit_cnt !== 16'd1) $display("FAIL slow_cnt got %0d exp 1", commit_cnt); else n_pass++;
    endtask

    task automatic test_scan_freeze();
        do_reset();
        commit(32'h11);
        op_commit = 1'b1; res_data = 32'h22;
        tick();
        sen = 1'b1; out_rdy = 1'b1; op_commit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++;
            if (commit_ack !== 1'b0 || out_val !== 1'b0 || count !== 3'd2)
                $display("FAIL frz_%0d got ack=%0b val=%0b count=%0d exp ack=0 val=0 count=2",
                         i, commit_ack, out_val, count);
            else n_pass++;
            tick();
        end
        sen = 1'b0;
        #1;
        n_total++; if (commit_ack !== 1'b1) $display("FAIL frz_ack_after got %0b exp 1", commit_ack); else n_pass++;
        n_total++; if (out_val !== 1'b1) $display("FAIL frz_val_after got %0b exp 1", out_val); else n_pass++;
        n_total++; if (out_data !== 32'h11) $display("FAIL frz_head got %h exp 11", out_data); else n_pass++;
        tick();
        out_rdy = 1'b0;
        n_total++; if (commit_ack !== 1'b0) $display("FAIL frz_ack_end got %0b exp 0", commit_ack); else n_pass++;
        n_total++; if (count !== 3'd1) $display("FAIL frz_count_end got %0d exp 1", count); else n_pass++;
        n_total++; if (out_data !== 32'h22) $display("FAIL frz_head2 got %h exp 22", out_data); else n_pass++;
        n_total++; if (commit_cnt !== 16'd2) $display("FAIL frz_cnt got %0d exp 2", commit_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        commit(32'hA);
        commit(32'hB);
        op_commit = 1'b1; res_data = 32'hC;
        tick();
        n_total++; if (count !== 3'd3 || commit_ack !== 1'b1)
            $display("FAIL mid_pre got count=%0d ack=%0b exp count=3 ack=1", count, commit_ack);
        else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_total++; if (commit_ack !== 1'b0) $display("FAIL mid_ack got %0b exp 0", commit_ack); else n_pass++;
        n_total++; if (out_val !== 1'b0) $display("FAIL mid_val got %0b exp 0", out_val); else n_pass++;
        n_total++; if (out_data !== 32'h0) $display("FAIL mid_data got %h exp 0", out_data); else n_pass++;
        n_total++; if (count !== 3'd0) $display("FAIL mid_count got %0d exp 0", count); else n_pass++;
        n_total++; if (commit_cnt !== 16'd0) $display("FAIL mid_cnt got %0d exp 0", commit_cnt); else n_pass++;
        tick();
        op_commit = 1'b0;
        n_total++; if (commit_ack !== 1'b1) $display("FAIL mid_recap_ack got %0b exp 1", commit_ack); else n_pass++;
        n_total++; if (commit_cnt !== 16'd1) $display("FAIL mid_recap_cnt got %0d exp 1", commit_cnt); else n_pass++;
        n_total++; if (out_data !== 32'hC) $display("FAIL mid_recap_data got %h exp c", out_data); else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_commit();
        test_fill_backpressure();
        test_push_pop_same_cycle();
        test_slow_producer();
        test_scan_freeze();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
